yutorina_insn_decoder: RTL and testbench
========================================

Name: yutorina_insn_decoder

Overview:
Instruction decoder for the Yutorina CPU, used inside the ID stage. It splits a 32-bit instruction into register read addresses and decodes ALU, memory, control, branch and exception information. Register addresses are combinational; all decode results are registered, one cycle later. The ID stage supplies forwarded GPR data and SPR read data.

Parameters:
none (widths fixed: word 32, word address 30, GPR address 5)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mode  in  1  0 = kernel, 1 = user
if_insn  in  32  instruction
if_pc  in  30  word address of the next instruction
gpr_r_data1  in  32  forwarded data for register ra
gpr_r_data2  in  32  forwarded data for register rb
spr_r_data  in  32  SPR read data
gpr_r_addr1  out  5  ra = if_insn[25:21] (combinational)
gpr_r_addr2  out  5  rb = if_insn[20:16] (combinational)
alu_op  out  4  0 NOP (pass lhs), 1 AND, 2 OR, 3 XOR, 4 ADDS, 5 ADDU, 6 SUBS, 7 SUBU, 8 SHRL, 9 SHLL
alu_lhs, alu_rhs  out  32 each  ALU operands
w_addr  out  5  destination GPR, or SPR address for WRCR
w_data  out  32  store data, or link value
gpr_we_  out  1  GPR write enable, active-low
br_taken  out  1  branch taken, active-high
br_addr  out  30  branch target (word address)
mem_op  out  4  0 NONE, 1 R_W, 2 R_H, 3 R_B, 4 R_HU, 5 R_BU, 6 W_W, 7 W_H, 8 W_B
ctrl_op  out  2  0 NONE, 1 LSR (read SPR), 2 SSR (write SPR), 3 EXRT
exp_code  out  3  0 NONE, 1 UNDEF, 2 TRAP, 3 PRV_VIO

Behaviour:
- Instruction fields: op = [31:26], ra, rb, rc = [15:11], imm = [15:0].
- sx = sign-extended imm; zx = zero-extended imm.
- Register read addresses follow if_insn with no delay. Every other output is registered on posedge clk.
- rst = 1 at a clock edge sets all registered outputs to 0, except gpr_we_ = 1.
- Default decode: NOP, all outputs 0, gpr_we_ = 1.
- Register ops (opcodes 00/02/04/06/08/0A/0B/0C/0E):
  - ops AND, OR, XOR, ADDS, ADDU, SUBS, SUBU, SHRL, SHLL.
  - lhs = data1, rhs = data2, w_addr = rc, write enabled.
- Immediate ops (opcodes 01/03/05/07/09/0D/0F):
  - ANDI, ORI, XORI use rhs = zx.
  - ADDSI, ADDUI use rhs = sx.
  - SHRLI, SHLLI use rhs = imm[4:0].
  - lhs = data1, w_addr = rb, write enabled.
- Conditional branches, each taken when its condition holds:
  - 10 BE: data1 == data2.
  - 11 BNE: data1 != data2.
  - 12 BSGT: signed data1 < data2.
  - 13 BUGT: unsigned data1 < data2.
  - Target br_addr = if_pc + sx[29:0], wrapping modulo 2^30.
- 14 JMP: always taken, br_addr = data1[31:2].
- 15 CALL: as JMP, plus w_addr = 31, w_data = {if_pc, 2'b00}, write enabled.
- Loads and stores:
  - Loads, opcodes 16 LDW, 1C LDH, 1D LDB, 1E LDHU, 1F LDBU.
  - Stores, opcodes 17 STW, 20 STH, 21 STB.
  - All use alu_op ADDU, lhs = data1, rhs = sx.
  - Load: w_addr = rb, write enabled, mem_op R_* accordingly.
  - Store: w_data = data2, write disabled, mem_op W_*.
- 18 TRAP: exp_code TRAP, nothing else.
- Privileged instructions (kernel mode only):
  - 19 RDCR: ctrl LSR, alu_op NOP, lhs = spr_r_data, w_addr = rb, write enabled.
  - 1A WRCR: ctrl SSR, lhs = data1, w_addr = rb, write disabled.
  - 1B EXRT: ctrl EXRT.
  - In user mode (mode = 1) all three produce only exp_code PRV_VIO; ctrl NONE, write disabled.
- Any other opcode: default decode with exp_code UNDEF.
- Branches and exceptions never assert gpr_we_ except CALL.

Test Plan:
- Reset: rst = 1 for 2 cycles with if_insn = ADDUR → all outputs 0, gpr_we_ = 1; ADDUR decode appears the cycle after rst falls.
- ADDUI, ra = 1, rb = 2, imm = 0xFFFF, data1 = 5 → next cycle alu_op 5, lhs 5, rhs 0xFFFFFFFF, w_addr 2, gpr_we_ 0; gpr_r_addr1 = 1 in the same cycle.
- BE, data1 = data2 = 7, if_pc = 0x100, imm = 0xFFFE → br_taken 1, br_addr 0xFE.
- BE with data1 = 7, data2 = 8 → br_taken 0.
- CALL, data1 = 0x400, if_pc = 0x20 → br_addr 0x100, w_addr 31, w_data 0x80, gpr_we_ 0.
- LDB, imm = 4, data1 = 0x1000 → mem_op 3, alu_op 5, rhs 4, ld target rb.
- STH → mem_op 7, w_data = data2, gpr_we_ 1.
- RDCR: mode = 0, spr_r_data = 0xA5 → ctrl 1, lhs 0xA5, gpr_we_ 0. mode = 1 → exp_code 3, ctrl 0, gpr_we_ 1.
- Opcode 0x3F → exp_code 1. TRAP → exp_code 2.

Source files
------------

// File: rtl/yutorina_insn_decoder.sv
// yutorina_insn_decoder: ID-stage decode with combinational GPR read addresses and registered decode results
module yutorina_insn_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [31:0] if_insn,
    input  logic [29:0] if_pc,
    input  logic [31:0] gpr_r_data1,
    input  logic [31:0] gpr_r_data2,
    input  logic [31:0] spr_r_data,
    output logic [4:0]  gpr_r_addr1,
    output logic [4:0]  gpr_r_addr2,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        gpr_we_,
    output logic        br_taken,
    output logic [29:0] br_addr,
    output logic [3:0]  mem_op,
    output logic [1:0]  ctrl_op,
    output logic [2:0]  exp_code
);
    logic [5:0]  op;
    logic [4:0]  rb, rc;
    logic [31:0] sx, zx, d1, d2;
    logic [3:0]  n_alu_op, n_mem_op;
    logic [31:0] n_lhs, n_rhs, n_w_data;
    logic [4:0]  n_w_addr;
    logic        n_we_, n_taken;
    logic [29:0] n_br_addr;
    logic [1:0]  n_ctrl;
    logic [2:0]  n_exp;

    assign op          = if_insn[31:26];
    assign gpr_r_addr1 = if_insn[25:21];
    assign gpr_r_addr2 = if_insn[20:16];
    assign rb          = if_insn[20:16];
    assign rc          = if_insn[15:11];
    assign sx          = {{16{if_insn[15]}}, if_insn[15:0]};
    assign zx          = {16'h0, if_insn[15:0]};
    assign d1          = gpr_r_data1;
    assign d2          = gpr_r_data2;

    always_comb begin
        n_alu_op  = 4'd0;
        n_lhs     = 32'h0;
        n_rhs     = 32'h0;
        n_w_addr  = 5'd0;
        n_w_data  = 32'h0;
        n_we_     = 1'b1;
        n_taken   = 1'b0;
        n_br_addr = 30'h0;
        n_mem_op  = 4'd0;
        n_ctrl    = 2'd0;
        n_exp     = 3'd0;
        case (op)
            6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0e: begin
                n_alu_op = op == 6'h00 ? 4'd1 : op == 6'h02 ? 4'd2 : op == 6'h04 ? 4'd3 :
                           op == 6'h06 ? 4'd4 : op == 6'h08 ? 4'd5 : op == 6'h0a ? 4'd6 :
                           op == 6'h0b ? 4'd7 : op == 6'h0c ? 4'd8 : 4'd9;
                n_lhs    = d1;
                n_rhs    = d2;
                n_w_addr = rc;
                n_we_    = 1'b0;
            end
            6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0d, 6'h0f: begin
                n_alu_op = op == 6'h01 ? 4'd1 : op == 6'h03 ? 4'd2 : op == 6'h05 ? 4'd3 :
                           op == 6'h07 ? 4'd4 : op == 6'h09 ? 4'd5 : op == 6'h0d ? 4'd8 : 4'd9;
                n_lhs    = d1;
                n_rhs    = op <= 6'h05 ? zx : op <= 6'h09 ? sx : {27'h0, if_insn[4:0]};
                n_w_addr = rb;
                n_we_    = 1'b0;
            end
            6'h10, 6'h11, 6'h12, 6'h13: begin
                n_taken   = op == 6'h10 ? d1 == d2 : op == 6'h11 ? d1 != d2 :
                            op == 6'h12 ? $signed(d1) < $signed(d2) : d1 < d2;
                n_br_addr = if_pc + sx[29:0];
            end
            6'h14, 6'h15: begin
                n_taken   = 1'b1;
                n_br_addr = d1[31:2];
                n_w_addr  = op == 6'h15 ? 5'd31 : 5'd0;
                n_w_data  = op == 6'h15 ? {if_pc, 2'b00} : 32'h0;
                n_we_     = op != 6'h15;
            end
            6'h16, 6'h1c, 6'h1d, 6'h1e, 6'h1f: begin
                n_alu_op = 4'd5;
                n_lhs    = d1;
                n_rhs    = sx;
                n_w_addr = rb;
                n_we_    = 1'b0;
                n_mem_op = op == 6'h16 ? 4'd1 : op == 6'h1c ? 4'd2 : op == 6'h1d ? 4'd3 :
                           op == 6'h1e ? 4'd4 : 4'd5;
            end
            6'h17, 6'h20, 6'h21: begin
                n_alu_op = 4'd5;
                n_lhs    = d1;
                n_rhs    = sx;
                n_w_data = d2;
                n_mem_op = op == 6'h17 ? 4'd6 : op == 6'h20 ? 4'd7 : 4'd8;
            end
            6'h18: n_exp = 3'd2;
            // privileged group collapses to a violation when issued from user mode
            6'h19, 6'h1a, 6'h1b: begin
                if (mode) n_exp = 3'd3;
                else begin
                    n_ctrl   = op == 6'h19 ? 2'd1 : op == 6'h1a ? 2'd2 : 2'd3;
                    n_lhs    = op == 6'h19 ? spr_r_data : op == 6'h1a ? d1 : 32'h0;
                    n_w_addr = op == 6'h1b ? 5'd0 : rb;
                    n_we_    = op != 6'h19;
                end
            end
            default: n_exp = 3'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op   <= 4'd0;
            alu_lhs  <= 32'h0;
            alu_rhs  <= 32'h0;
            w_addr   <= 5'd0;
            w_data   <= 32'h0;
            gpr_we_  <= 1'b1;
            br_taken <= 1'b0;
            br_addr  <= 30'h0;
            mem_op   <= 4'd0;
            ctrl_op  <= 2'd0;
            exp_code <= 3'd0;
        end else begin
            alu_op   <= n_alu_op;
            alu_lhs  <= n_lhs;
            alu_rhs  <= n_rhs;
            w_addr   <= n_w_addr;
            w_data   <= n_w_data;
            gpr_we_  <= n_we_;
            br_taken <= n_taken;
            br_addr  <= n_br_addr;
            mem_op   <= n_mem_op;
            ctrl_op  <= n_ctrl;
            exp_code <= n_exp;
        end
    end
endmodule

// File: tb/tb_yutorina_insn_decoder.sv
// tb_yutorina_insn_decoder: directed vectors, expected decode queued at issue and checked by a monitor
module tb_yutorina_insn_decoder;
    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic        we_;
        logic        taken;
        logic [29:0] br_addr;
        logic [3:0]  mem_op;
        logic [1:0]  ctrl;
        logic [2:0]  exp;
    } exp_t;

    logic        clk = 0, rst = 1, mode = 0;
    logic [31:0] if_insn = 0, gpr_r_data1 = 0, gpr_r_data2 = 0, spr_r_data = 0;
    logic [29:0] if_pc = 0;
    logic [4:0]  gpr_r_addr1, gpr_r_addr2, w_addr;
    logic [3:0]  alu_op, mem_op;
    logic [31:0] alu_lhs, alu_rhs, w_data;
    logic        gpr_we_, br_taken;
    logic [29:0] br_addr;
    logic [1:0]  ctrl_op;
    logic [2:0]  exp_code;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0, errors = 0;

    yutorina_insn_decoder dut (
        .clk(clk), .rst(rst), .mode(mode), .if_insn(if_insn), .if_pc(if_pc),
        .gpr_r_data1(gpr_r_data1), .gpr_r_data2(gpr_r_data2), .spr_r_data(spr_r_data),
        .gpr_r_addr1(gpr_r_addr1), .gpr_r_addr2(gpr_r_addr2), .alu_op(alu_op),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .w_addr(w_addr), .w_data(w_data),
        .gpr_we_(gpr_we_), .br_taken(br_taken), .br_addr(br_addr), .mem_op(mem_op),
        .ctrl_op(ctrl_op), .exp_code(exp_code)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic exp_t e(input logic [3:0] a, input logic [31:0] l, input logic [31:0] r,
                               input logic [4:0] wa, input logic [31:0] wd, input logic we,
                               input logic tk, input logic [29:0] ba, input logic [3:0] m,
                               input logic [1:0] c, input logic [2:0] x);
        return {a, l, r, wa, wd, we, tk, ba, m, c, x};
    endfunction

    task automatic apply(input string nm, input logic r, input logic md, input logic [31:0] insn,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] spr,
                         input logic [29:0] pc, input exp_t ex);
        @(negedge clk);
        rst = r; mode = md; if_insn = insn; gpr_r_data1 = d1; gpr_r_data2 = d2;
        spr_r_data = spr; if_pc = pc;
        #1;
        checks++;
        if (gpr_r_addr1 !== insn[25:21] || gpr_r_addr2 !== insn[20:16]) begin
            errors++;
            $display("FAIL %s raddr: got %0d/%0d expected %0d/%0d", nm, gpr_r_addr1, gpr_r_addr2, insn[25:21], insn[20:16]);
        end
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    initial begin
        exp_t got, ex;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {alu_op, alu_lhs, alu_rhs, w_addr, w_data, gpr_we_, br_taken, br_addr, mem_op, ctrl_op, exp_code};
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", nm, got, ex);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        logic [31:0] addur;
        addur = ins(6'h08, 5'd1, 5'd2, 16'h1800);
        apply("reset0", 1, 0, addur, 5, 6, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply("reset1", 1, 0, addur, 5, 6, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply("addur", 0, 0, addur, 5, 6, 0, 0, e(5, 5, 6, 3, 0, 0, 0, 0, 0, 0, 0));
        apply("addui", 0, 0, ins(6'h09, 1, 2, 16'hffff), 5, 0, 0, 0, e(5, 5, 32'hffffffff, 2, 0, 0, 0, 0, 0, 0, 0));
        apply("subs", 0, 0, ins(6'h0a, 3, 4, 16'h2800), 9, 2, 0, 0, e(6, 9, 2, 5, 0, 0, 0, 0, 0, 0, 0));
        apply("ori", 0, 0, ins(6'h03, 1, 7, 16'h8001), 1, 0, 0, 0, e(2, 1, 32'h8001, 7, 0, 0, 0, 0, 0, 0, 0));
        apply("shlli", 0, 0, ins(6'h0f, 1, 8, 16'h1234), 3, 0, 0, 0, e(9, 3, 32'h14, 8, 0, 0, 0, 0, 0, 0, 0));
        apply("be_taken", 0, 0, ins(6'h10, 1, 2, 16'hfffe), 7, 7, 0, 30'h100, e(0, 0, 0, 0, 0, 1, 1, 30'hfe, 0, 0, 0));
        apply("be_not", 0, 0, ins(6'h10, 1, 2, 16'hfffe), 7, 8, 0, 30'h100, e(0, 0, 0, 0, 0, 1, 0, 30'hfe, 0, 0, 0));
        apply("bsgt_signed", 0, 0, ins(6'h12, 1, 2, 16'h0004), 32'hffffffff, 1, 0, 30'h10, e(0, 0, 0, 0, 0, 1, 1, 30'h14, 0, 0, 0));
        apply("bugt_unsigned", 0, 0, ins(6'h13, 1, 2, 16'h0004), 32'hffffffff, 1, 0, 30'h10, e(0, 0, 0, 0, 0, 1, 0, 30'h14, 0, 0, 0));
        apply("bne_wrap", 0, 0, ins(6'h11, 1, 2, 16'h0002), 1, 2, 0, 30'h3fffffff, e(0, 0, 0, 0, 0, 1, 1, 30'h1, 0, 0, 0));
        apply("jmp", 0, 0, ins(6'h14, 1, 0, 0), 32'h403, 0, 0, 30'h20, e(0, 0, 0, 0, 0, 1, 1, 30'h100, 0, 0, 0));
        apply("call", 0, 0, ins(6'h15, 1, 0, 0), 32'h400, 0, 0, 30'h20, e(0, 0, 0, 31, 32'h80, 0, 1, 30'h100, 0, 0, 0));
        apply("ldb", 0, 0, ins(6'h1d, 1, 4, 16'h0004), 32'h1000, 0, 0, 0, e(5, 32'h1000, 4, 4, 0, 0, 0, 0, 3, 0, 0));
        apply("sth", 0, 0, ins(6'h20, 1, 5, 16'hfff8), 32'h2000, 32'hdeadbeef, 0, 0, e(5, 32'h2000, 32'hfffffff8, 0, 32'hdeadbeef, 1, 0, 0, 7, 0, 0));
        apply("rdcr_kernel", 0, 0, ins(6'h19, 0, 6, 0), 0, 0, 32'ha5, 0, e(0, 32'ha5, 0, 6, 0, 0, 0, 0, 0, 1, 0));
        apply("rdcr_user", 0, 1, ins(6'h19, 0, 6, 0), 0, 0, 32'ha5, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
        apply("wrcr_kernel", 0, 0, ins(6'h1a, 1, 3, 0), 32'h55, 0, 0, 0, e(0, 32'h55, 0, 3, 0, 1, 0, 0, 0, 2, 0));
        apply("exrt_kernel", 0, 0, ins(6'h1b, 0, 0, 0), 0, 0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0));
        apply("undef", 0, 0, ins(6'h3f, 1, 2, 16'h1234), 1, 2, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        apply("trap", 0, 0, ins(6'h18, 1, 2, 0), 1, 2, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never checked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
